// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetch FIFO with redirect flush; `FETCH_PFQ_BYPASS_EN adds an ack-to-fetch bypass
module fetch_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    input  logic        stallF,
    output logic [31:0] instrF,
    output logic        ivalidF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} stateT;

    logic [31:0] addrQ [DEPTH];
    logic [31:0] instrQ [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0] count, countNext;
    stateT state, stateNext;
    logic [31:0] raddr, raddrNext, tgt, tgtNext, expAddr;
    logic hit, redirect, bypass, consume, push, pop;

`ifdef FETCH_PFQ_BYPASS_EN
    assign bypass = (count == '0) && (state == REQ) && imem_ack && (raddr == pcF);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        hit = (count != '0) && (addrQ[head] == pcF);
        expAddr = (state == DISCARD) ? tgt : raddr;
        redirect = (count != '0) ? (addrQ[head] != pcF) : (expAddr != pcF);
        consume = bypass && !stallF;
        push = (state == REQ) && imem_ack && !redirect && !consume;
        pop = hit && !stallF;
        countNext = redirect ? '0 : count + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_comb begin
        stateNext = state;
        raddrNext = raddr;
        tgtNext = tgt;
        case (state)
            IDLE: begin
                raddrNext = redirect ? pcF : raddr;
                stateNext = (redirect || countNext < FULL) ? REQ : IDLE;
            end
            REQ: begin
                if (imem_ack) begin
                    raddrNext = redirect ? pcF : raddr + 32'd4;
                    stateNext = (redirect || countNext < FULL) ? REQ : IDLE;
                end else if (redirect) begin
                    tgtNext = pcF;
                    stateNext = DISCARD;
                end
            end
            DISCARD: begin
                tgtNext = redirect ? pcF : tgt;
                if (imem_ack) begin
                    raddrNext = redirect ? pcF : tgt;
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            raddr <= '0;
            tgt <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            state <= stateNext;
            raddr <= raddrNext;
            tgt <= tgtNext;
            head <= redirect ? tail : head + AW'(pop);
            tail <= tail + AW'(push);
            count <= countNext;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            addrQ[tail] <= raddr;
            instrQ[tail] <= imem_rdata;
        end
    end

    assign imem_req = (state != IDLE);
    assign imem_addr = raddr;
    assign ivalidF = hit || bypass;
    assign instrF = hit ? instrQ[head] : (bypass ? imem_rdata : 32'h0);
endmodule
